regfile_banked: RTL and testbench
=================================

# regfile_banked

Parametrised successor to the single-hart register file: one banked register array holding the architectural integer registers for `NHARTS` hardware threads, with `NRD` read ports, `NWR` write ports, same-cycle write-to-read bypass, and a per-register pending (scoreboard) bit. It sits in the decode/writeback path of the multicore RISC-V pipeline. Decode reads operands and reserves destinations; the writeback ports (ALU and load/store) retire results.

## Interface
Parameters:
- `XLEN`, 32, register width
- `NREGS`, 32, registers per hart; power of two, ≥ 2
- `NHARTS`, 2, hart banks; ≥ 1
- `NRD`, 2, read ports
- `NWR`, 2, write ports

Derived values:
- `AW = $clog2(NREGS)`
- `HW = max(1, $clog2(NHARTS))`

Ports:
- `clk` in 1: single clock; all state updates on the rising edge
- `rst` in 1: synchronous, active-high reset
- `register_file_enable` in 1: block enable
- `rd_hart` in HW: hart selected for all read ports
- `rs_add` in NRD*AW: read addresses, port i at `[i*AW +: AW]`
- `rs_val` out NRD*XLEN: read data
- `rs_busy` out NRD: pending bit of each read register
- `wen` in NWR: per-port write enable
- `wr_hart` in NWR*HW: per-port hart
- `rd_add` in NWR*AW: per-port destination
- `wr_data` in NWR*XLEN: per-port data
- `rsv_en` in 1: reserve request
- `rsv_hart` in HW: hart of the register to reserve
- `rsv_add` in AW: register to reserve

## Operation
Writes and reserves:
- Write port j is effective when `wen[j] & register_file_enable & !rst`, `rd_add[j] != 0`, and `wr_hart[j] < NHARTS`.
- An effective write stores `wr_data[j]` into `reg[wr_hart][rd_add]` and clears its pending bit.
- Two effective writes to the same hart+address in one cycle: the highest port index wins, for both the stored data and the bypass.
- A reserve is effective when `rsv_en & register_file_enable & !rst`, `rsv_add != 0`, and the hart is in range. It sets the pending bit.
- Reserve and write to the same register in one cycle: the reserve wins (new producer). Data is still written and the pending bit ends up 1.

Reads (combinational):
- Address 0 returns `rs_val = 0` and `rs_busy = 0`.
- Any out-of-range `rd_hart` returns 0 / 0.
- If an effective write targets the same hart+address in the current cycle, `rs_val` returns that port's `wr_data` (highest index), and `rs_busy` returns 0 unless a same-cycle reserve also targets it.
- Otherwise the outputs are the array value and the pending bit.
- When `register_file_enable = 0`: all `rs_val = 0`, all `rs_busy = 0`, and no state changes.

Reset:
- While `rst` is high, all outputs are 0.
- On any edge with `rst = 1`, every register and pending bit of every hart is cleared to 0.
- Writes and reserves in that cycle are discarded. Reset in the middle of a reserve/write sequence leaves no pending bits set.

Register 0 of every hart is hardwired 0 and never pending; no storage is needed.

## Timing
- Write: array updated at the edge where the write is effective. Visible on `rs_val` in the same cycle via bypass, and from the array on the following cycle.
- Reserve: `rs_busy` rises in the cycle after `rsv_en` is sampled. There is no same-cycle reserve bypass except in the reserve-and-write case above.
- Pending clear: `rs_busy` drops combinationally in the cycle of the clearing write, and is stored cleared from the next cycle.
- No handshake back-pressure: every write and reserve is accepted in one cycle. Callers stall on `rs_busy`.
- Read-port count is independent of write-port count. There are no port conflicts.

## Structure
- Package `rf_pkg` holds:
  - default `XLEN`, `NREGS`, `NHARTS`
  - `typedef logic [4:0] reg_addr_t` for the default configuration
  - constant `ZERO_REG = 0`
- Sub-module `rf_bank`, instantiated once per hart, contains:
  - the `NREGS-1` × `XLEN` storage
  - the pending vector
  - per-port write decode with priority
  - raw read muxes
- The top level handles hart selection, bypass and the enable/reset gating of outputs.

## Test plan
- **Reset:** Hold `rst` for 2 cycles after random writes. Required: every `rs_val` = 0 and `rs_busy` = 0 for all harts and registers.
- **Write then read:** Write hart 0 `x1 = 32'h5` and `x2 = 32'hA` on ports 0 and 1 in the same cycle, then read `x1`/`x2`. Required: `5`/`A`. Hart 1 `x1` still reads 0.
- **Bypass and priority:** In one cycle, port 0 writes hart 1 `x17 = 32'hB`, port 1 writes hart 1 `x17 = 32'hC`, and read port 0 reads hart 1 `x17`. Required: `rs_val = 32'hC` in that cycle and on the next cycle.
- **x0:** Write `x0 = 32'h2`, then read `x0` on both ports. Required: 0, `rs_busy` 0. Reserve `x0`: `rs_busy` stays 0.
- **Scoreboard:** Reserve hart 0 `x3`. Required: `rs_busy = 1` next cycle. Write `x3 = 32'h7`: `rs_busy = 0` and `rs_val = 7` in the same cycle. Reserve and write `x4` together: `rs_busy = 1` next cycle and `rs_val` = the written data.
- **Enable low:** With `register_file_enable = 0`, write `x5 = 32'h9`. Required: outputs 0. Re-enable: `x5` reads 0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared defaults and types for the banked integer register file.
// No logic and no latency of its own.
// No flow control.
package rf_pkg;
    localparam int DEF_XLEN   = 32;
    localparam int DEF_NREGS  = 32;
    localparam int DEF_NHARTS = 2;

    typedef logic [4:0] reg_addr_t;

    localparam int ZERO_REG = 0;
endpackage

// File: rtl/rf_bank.sv
// One hart's register storage (x1..xN-1) with a pending bit per register.
// Writes and reserves land on the clock edge; reads are raw and combinational.
// Always ready: every write and reserve is accepted in its cycle.
module rf_bank
    import rf_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int NREGS = DEF_NREGS,
    parameter int NRD   = 2,
    parameter int NWR   = 2,
    parameter int AW    = $clog2(DEF_NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   wa,
    input  logic [NWR*XLEN-1:0] wd,
    input  logic                rsv,
    input  logic [AW-1:0]       rsv_add,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rv,
    output logic [NRD-1:0]      rb
);
    logic [XLEN-1:0]  mem_q [NREGS-1:1];
    logic [XLEN-1:0]  mem_d [NREGS-1:1];
    logic [NREGS-1:1] pend_q;
    logic [NREGS-1:1] pend_d;

    // Later ports overwrite earlier ones; a reserve is applied last so it beats a retiring write.
    always_comb begin
        mem_d  = mem_q;
        pend_d = pend_q;
        for (int r = 1; r < NREGS; r++) begin
            for (int j = 0; j < NWR; j++) begin
                if (we[j] && (wa[j*AW +: AW] == AW'(r))) begin
                    mem_d[r]  = wd[j*XLEN +: XLEN];
                    pend_d[r] = 1'b0;
                end
            end
            if (rsv && (rsv_add == AW'(r))) begin
                pend_d[r] = 1'b1;
            end
        end
        if (rst) begin
            mem_d  = '{default: '0};
            pend_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        mem_q  <= mem_d;
        pend_q <= pend_d;
    end

    always_comb begin
        rv = '0;
        rb = '0;
        for (int i = 0; i < NRD; i++) begin
            for (int r = 1; r < NREGS; r++) begin
                if (ra[i*AW +: AW] == AW'(r)) begin
                    rv[i*XLEN +: XLEN] = mem_q[r];
                    rb[i]              = pend_q[r];
                end
            end
        end
    end
endmodule

// File: rtl/regfile_banked.sv
// Multi-hart register file: hart-banked storage, write-to-read bypass, pending scoreboard.
// Reads are combinational (same-cycle bypass); writes/reserves take effect at the edge.
// No back-pressure: callers stall on rs_busy.
module regfile_banked
    import rf_pkg::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int NREGS  = DEF_NREGS,
    parameter int NHARTS = DEF_NHARTS,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    localparam int AW    = $clog2(NREGS),
    localparam int HW    = (NHARTS > 1) ? $clog2(NHARTS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                register_file_enable,
    input  logic [HW-1:0]       rd_hart,
    input  logic [NRD*AW-1:0]   rs_add,
    output logic [NRD*XLEN-1:0] rs_val,
    output logic [NRD-1:0]      rs_busy,
    input  logic [NWR-1:0]      wen,
    input  logic [NWR*HW-1:0]   wr_hart,
    input  logic [NWR*AW-1:0]   rd_add,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                rsv_en,
    input  logic [HW-1:0]       rsv_hart,
    input  logic [AW-1:0]       rsv_add
);
    logic [NWR-1:0]      wr_eff;
    logic                rsv_eff;
    logic [NWR-1:0]      bank_we [NHARTS];
    logic [NHARTS-1:0]   bank_rsv;
    logic [NRD*XLEN-1:0] bank_val [NHARTS];
    logic [NRD-1:0]      bank_busy [NHARTS];

    // Hart range is enforced by the bank decode: an out-of-range hart matches no bank.
    always_comb begin
        wr_eff   = '0;
        bank_we  = '{default: '0};
        bank_rsv = '0;
        for (int j = 0; j < NWR; j++) begin
            wr_eff[j] = wen[j] & register_file_enable & ~rst &
                        (rd_add[j*AW +: AW] != AW'(ZERO_REG));
        end
        rsv_eff = rsv_en & register_file_enable & ~rst & (rsv_add != AW'(ZERO_REG));
        for (int b = 0; b < NHARTS; b++) begin
            for (int j = 0; j < NWR; j++) begin
                bank_we[b][j] = wr_eff[j] && (wr_hart[j*HW +: HW] == HW'(b));
            end
            bank_rsv[b] = rsv_eff && (rsv_hart == HW'(b));
        end
    end

    for (genvar b = 0; b < NHARTS; b++) begin : g_bank
        rf_bank #(
            .XLEN  (XLEN),
            .NREGS (NREGS),
            .NRD   (NRD),
            .NWR   (NWR),
            .AW    (AW)
        ) u_bank (
            .clk     (clk),
            .rst     (rst),
            .we      (bank_we[b]),
            .wa      (rd_add),
            .wd      (wr_data),
            .rsv     (bank_rsv[b]),
            .rsv_add (rsv_add),
            .ra      (rs_add),
            .rv      (bank_val[b]),
            .rb      (bank_busy[b])
        );
    end

    always_comb begin
        logic [XLEN-1:0] val;
        logic            busy;
        logic            hart_ok;
        logic [AW-1:0]   ra;
        rs_val  = '0;
        rs_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            val     = '0;
            busy    = 1'b0;
            hart_ok = 1'b0;
            ra      = rs_add[i*AW +: AW];
            for (int b = 0; b < NHARTS; b++) begin
                if (rd_hart == HW'(b)) begin
                    hart_ok = 1'b1;
                    val     = bank_val[b][i*XLEN +: XLEN];
                    busy    = bank_busy[b][i];
                end
            end
            // wr_eff already excludes x0, so a bypass hit never targets register 0.
            for (int j = 0; j < NWR; j++) begin
                if (wr_eff[j] && (wr_hart[j*HW +: HW] == rd_hart) && (rd_add[j*AW +: AW] == ra)) begin
                    val  = wr_data[j*XLEN +: XLEN];
                    busy = rsv_eff && (rsv_hart == rd_hart) && (rsv_add == ra);
                end
            end
            if (!hart_ok || !register_file_enable || rst) begin
                val  = '0;
                busy = 1'b0;
            end
            rs_val[i*XLEN +: XLEN] = val;
            rs_busy[i]             = busy;
        end
    end
endmodule

// File: tb/tb_regfile_banked.sv
// Randomised and directed check of regfile_banked against an array-based reference model.
module tb_regfile_banked;
    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int NHARTS = 3;
    localparam int NRD    = 2;
    localparam int NWR    = 2;
    localparam int AW     = $clog2(NREGS);
    localparam int HW     = 2;

    logic                clk;
    logic                rst;
    logic                en;
    logic [HW-1:0]       rd_hart;
    logic [NRD*AW-1:0]   rs_add;
    logic [NRD*XLEN-1:0] rs_val;
    logic [NRD-1:0]      rs_busy;
    logic [NWR-1:0]      wen;
    logic [NWR*HW-1:0]   wr_hart;
    logic [NWR*AW-1:0]   rd_add;
    logic [NWR*XLEN-1:0] wr_data;
    logic                rsv_en;
    logic [HW-1:0]       rsv_hart;
    logic [AW-1:0]       rsv_add;

    int n_checks = 0;
    int n_fail   = 0;

    logic [XLEN-1:0] m_val  [NHARTS][NREGS];
    bit              m_pend [NHARTS][NREGS];

    regfile_banked #(
        .XLEN(XLEN), .NREGS(NREGS), .NHARTS(NHARTS), .NRD(NRD), .NWR(NWR)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .register_file_enable (en),
        .rd_hart              (rd_hart),
        .rs_add               (rs_add),
        .rs_val               (rs_val),
        .rs_busy              (rs_busy),
        .wen                  (wen),
        .wr_hart              (wr_hart),
        .rd_add               (rd_add),
        .wr_data              (wr_data),
        .rsv_en               (rsv_en),
        .rsv_hart             (rsv_hart),
        .rsv_add              (rsv_add)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit wr_ok(input int j);
        int h;
        int a;
        h = int'(wr_hart[j*HW +: HW]);
        a = int'(rd_add[j*AW +: AW]);
        return wen[j] && en && !rst && (a != 0) && (h < NHARTS);
    endfunction

    function automatic bit rsv_ok();
        return rsv_en && en && !rst && (rsv_add != 0) && (int'(rsv_hart) < NHARTS);
    endfunction

    function automatic void exp_port(input int i, output logic [XLEN-1:0] v, output logic b);
        int h;
        int a;
        h = int'(rd_hart);
        a = int'(rs_add[i*AW +: AW]);
        v = '0;
        b = 1'b0;
        if (rst || !en || h >= NHARTS || a == 0) return;
        v = m_val[h][a];
        b = m_pend[h][a];
        for (int j = 0; j < NWR; j++) begin
            if (wr_ok(j) && int'(wr_hart[j*HW +: HW]) == h && int'(rd_add[j*AW +: AW]) == a) begin
                v = wr_data[j*XLEN +: XLEN];
                b = rsv_ok() && int'(rsv_hart) == h && int'(rsv_add) == a;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_check();
        logic [XLEN-1:0] v;
        logic            b;
        for (int i = 0; i < NRD; i++) begin
            exp_port(i, v, b);
            chk($sformatf("model_val%0d", i), rs_val[i*XLEN +: XLEN], v);
            chk($sformatf("model_busy%0d", i), XLEN'(rs_busy[i]), XLEN'(b));
        end
    endtask

    task automatic model_update();
        if (rst) begin
            for (int h = 0; h < NHARTS; h++)
                for (int r = 0; r < NREGS; r++) begin
                    m_val[h][r]  = '0;
                    m_pend[h][r] = 1'b0;
                end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_ok(j)) begin
                    m_val[int'(wr_hart[j*HW +: HW])][int'(rd_add[j*AW +: AW])]  = wr_data[j*XLEN +: XLEN];
                    m_pend[int'(wr_hart[j*HW +: HW])][int'(rd_add[j*AW +: AW])] = 1'b0;
                end
            end
            if (rsv_ok()) m_pend[int'(rsv_hart)][int'(rsv_add)] = 1'b1;
        end
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic cyc();
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_idle();
        rst = 1'b0; en = 1'b1; wen = '0; wr_hart = '0; rd_add = '0; wr_data = '0;
        rsv_en = 1'b0; rsv_hart = '0; rsv_add = '0;
    endtask

    task automatic set_wr(input int p, input int h, input int a, input logic [XLEN-1:0] d);
        wen[p] = 1'b1;
        wr_hart[p*HW +: HW] = HW'(h);
        rd_add[p*AW +: AW]  = AW'(a);
        wr_data[p*XLEN +: XLEN] = d;
    endtask

    task automatic set_rd(input int h, input int a0, input int a1);
        rd_hart = HW'(h);
        rs_add[0 +: AW]  = AW'(a0);
        rs_add[AW +: AW] = AW'(a1);
    endtask

    task automatic lit(input string name, input int p, input logic [XLEN-1:0] v, input logic b);
        #2;
        chk({name, "_val"}, rs_val[p*XLEN +: XLEN], v);
        chk({name, "_busy"}, XLEN'(rs_busy[p]), XLEN'(b));
    endtask

    initial begin
        for (int h = 0; h < NHARTS; h++)
            for (int r = 0; r < NREGS; r++) begin
                m_val[h][r]  = '0;
                m_pend[h][r] = 1'b0;
            end
        set_idle();
        rd_hart = '0;
        rs_add  = '0;
        rst = 1'b1;
        #1;
        cyc();
        cyc();
        rst = 1'b0;

        set_wr(0, 0, 1, 32'h5);
        set_wr(1, 0, 2, 32'hA);
        cyc();
        wen = '0;
        set_rd(0, 1, 2);
        lit("wr_x1", 0, 32'h5, 1'b0);
        lit("wr_x2", 1, 32'hA, 1'b0);
        cyc();
        set_rd(1, 1, 1);
        lit("hart1_x1", 0, 32'h0, 1'b0);
        cyc();

        set_wr(0, 1, 17, 32'hB);
        set_wr(1, 1, 17, 32'hC);
        set_rd(1, 17, 0);
        lit("bypass_prio", 0, 32'hC, 1'b0);
        cyc();
        wen = '0;
        lit("stored_prio", 0, 32'hC, 1'b0);
        cyc();

        set_wr(0, 0, 0, 32'h2);
        cyc();
        wen = '0;
        set_rd(0, 0, 0);
        lit("x0_p0", 0, 32'h0, 1'b0);
        lit("x0_p1", 1, 32'h0, 1'b0);
        rsv_en = 1'b1; rsv_hart = 2'd0; rsv_add = '0;
        cyc();
        rsv_en = 1'b0;
        lit("x0_rsv", 0, 32'h0, 1'b0);
        cyc();

        rsv_en = 1'b1; rsv_add = AW'(3);
        set_rd(0, 3, 4);
        lit("rsv_same_cycle", 0, 32'h0, 1'b0);
        cyc();
        rsv_en = 1'b0;
        lit("rsv_next", 0, 32'h0, 1'b1);
        cyc();
        set_wr(0, 0, 3, 32'h7);
        lit("clear_bypass", 0, 32'h7, 1'b0);
        cyc();
        wen = '0;
        lit("clear_stored", 0, 32'h7, 1'b0);
        cyc();
        rsv_en = 1'b1; rsv_add = AW'(4);
        set_wr(1, 0, 4, 32'h1234);
        lit("rsv_wr_same", 1, 32'h1234, 1'b1);
        cyc();
        rsv_en = 1'b0; wen = '0;
        lit("rsv_wr_next", 1, 32'h1234, 1'b1);
        cyc();

        en = 1'b0;
        set_wr(0, 0, 5, 32'h9);
        set_rd(0, 5, 1);
        lit("en_low", 0, 32'h0, 1'b0);
        lit("en_low_x1", 1, 32'h0, 1'b0);
        cyc();
        en = 1'b1; wen = '0;
        lit("en_back_x5", 0, 32'h0, 1'b0);
        cyc();

        set_wr(0, 3, 6, 32'hDEAD);
        set_rd(3, 6, 1);
        lit("bad_hart_rd", 0, 32'h0, 1'b0);
        cyc();
        wen = '0;
        set_rd(0, 6, 1);
        lit("bad_hart_wr", 0, 32'h0, 1'b0);
        lit("hart0_x1_kept", 1, 32'h5, 1'b0);
        cyc();

        for (int n = 0; n < 3000; n++) begin
            rst    = ($urandom_range(0, 99) < 2);
            en     = ($urandom_range(0, 9) != 0);
            rsv_en = ($urandom_range(0, 9) < 3);
            rsv_hart = HW'($urandom_range(0, 3));
            rsv_add  = AW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, NREGS - 1));
            rd_hart  = HW'($urandom_range(0, 3));
            for (int i = 0; i < NRD; i++)
                rs_add[i*AW +: AW] = AW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, NREGS - 1));
            for (int j = 0; j < NWR; j++) begin
                wen[j] = ($urandom_range(0, 1) == 1);
                wr_hart[j*HW +: HW] = HW'($urandom_range(0, 3));
                rd_add[j*AW +: AW]  = AW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, NREGS - 1));
                wr_data[j*XLEN +: XLEN] = XLEN'($urandom);
            end
            cyc();
        end

        set_idle();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        for (int h = 0; h < NHARTS; h++) begin
            for (int r = 0; r < NREGS; r += 2) begin
                set_rd(h, r, r + 1);
                lit("post_rst_a", 0, 32'h0, 1'b0);
                lit("post_rst_b", 1, 32'h0, 1'b0);
                cyc();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
